// File: rtl/tdm_demultiplexer_pkg.sv
// Shared definitions for the 4-channel TDM link (multiplexer and demultiplexer sides).
package tdm_demultiplexer_pkg;

   // Frame alignment tracker state
   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int NUM_SLOTS = 4;

   localparam logic [1:0] SLOT_A = 2'd0;
   localparam logic [1:0] SLOT_B = 2'd1;
   localparam logic [1:0] SLOT_C = 2'd2;
   localparam logic [1:0] SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_demultiplexer_if.sv
// Serial link input plus per-channel frame outputs of the TDM demultiplexer.
interface tdm_demultiplexer_if #(
   parameter int W = 2
);
   logic [W-1:0] DIN;
   logic         DIN_VALID;
   logic         FRAME_SYNC;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] C;
   logic [W-1:0] D;
   logic         FRAME_VALID;
   logic [1:0]   SEL;
   logic         LOCKED;
   logic         SYNC_ERR;

   // Link driver / channel consumer side
   modport master (
      output DIN, DIN_VALID, FRAME_SYNC,
      input  A, B, C, D, FRAME_VALID, SEL, LOCKED, SYNC_ERR
   );

   // Demultiplexer side
   modport slave (
      input  DIN, DIN_VALID, FRAME_SYNC,
      output A, B, C, D, FRAME_VALID, SEL, LOCKED, SYNC_ERR
   );
endinterface

// File: rtl/tdm_demultiplexer.sv
// Receive end of the 4-slot TDM link: locks onto FRAME_SYNC, stages slots 0..2,
// and publishes A..D atomically when slot 3 arrives.
module tdm_demultiplexer
   import tdm_demultiplexer_pkg::*;
#(
   parameter int W = 2
) (
   input logic                CLK,
   input logic                RST,
   tdm_demultiplexer_if.slave bus
);

   localparam int NUM_STAGE = NUM_SLOTS - 1;

   state_t         state_reg, state_next;
   logic [1:0]     sel_reg, sel_next;
   logic [W-1:0]   stage_reg [NUM_STAGE];
   logic           stage_load [NUM_STAGE];
   logic [W-1:0]   out_reg [NUM_SLOTS];
   logic           commit;
   logic           frame_valid_reg, frame_valid_next;
   logic           sync_err_reg, sync_err_next;

   // Next-state, slot counter and pulse decisions for each valid beat
   always_comb begin
      state_next       = state_reg;
      sel_next         = sel_reg;
      commit           = 1'b0;
      frame_valid_next = 1'b0;
      sync_err_next    = 1'b0;
      for (int i = 0; i < NUM_STAGE; i++) begin
         stage_load[i] = 1'b0;
      end

      if (bus.DIN_VALID) begin
         case (state_reg)
            HUNT: begin
               if (bus.FRAME_SYNC) begin
                  stage_load[0] = 1'b1;
                  sel_next      = SLOT_B;
                  state_next    = LOCKED;
               end
            end
            LOCKED: begin
               if (sel_reg == SLOT_A) begin
                  if (bus.FRAME_SYNC) begin
                     stage_load[0] = 1'b1;
                     sel_next      = SLOT_B;
                  end else begin
                     // Missing sync: drop the beat and search again
                     sync_err_next = 1'b1;
                     sel_next      = SLOT_A;
                     state_next    = HUNT;
                  end
               end else if (bus.FRAME_SYNC) begin
                  // Early sync: abandon partial frame, this beat starts a new one
                  sync_err_next = 1'b1;
                  stage_load[0] = 1'b1;
                  sel_next      = SLOT_B;
               end else if (sel_reg == SLOT_D) begin
                  commit           = 1'b1;
                  frame_valid_next = 1'b1;
                  sel_next         = SLOT_A;
               end else begin
                  for (int i = 1; i < NUM_STAGE; i++) begin
                     if (sel_reg == 2'(i)) begin
                        stage_load[i] = 1'b1;
                     end
                  end
                  sel_next = sel_reg + 2'd1;
               end
            end
            default: begin
               state_next = HUNT;
               sel_next   = SLOT_A;
            end
         endcase
      end
   end

   // State, slot counter and status pulses
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg       <= HUNT;
         sel_reg         <= SLOT_A;
         frame_valid_reg <= 1'b0;
         sync_err_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         sel_reg         <= sel_next;
         frame_valid_reg <= frame_valid_next;
         sync_err_reg    <= sync_err_next;
      end
   end

   // One staging register per slot 0..2; slot 3 goes straight to the outputs
   generate
      for (genvar gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
         // Capture DIN when this slot is accepted
         always_ff @(posedge CLK) begin
            if (RST) begin
               stage_reg[gi] <= '0;
            end else if (stage_load[gi]) begin
               stage_reg[gi] <= bus.DIN;
            end
         end
      end
   endgenerate

   // Output bank updated only on a complete frame so A..D never mix frames
   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_out
         if (gi < NUM_STAGE) begin : g_staged
            // Publish staged slot on commit
            always_ff @(posedge CLK) begin
               if (RST) begin
                  out_reg[gi] <= '0;
               end else if (commit) begin
                  out_reg[gi] <= stage_reg[gi];
               end
            end
         end else begin : g_last
            // Publish the live slot-3 beat on commit
            always_ff @(posedge CLK) begin
               if (RST) begin
                  out_reg[gi] <= '0;
               end else if (commit) begin
                  out_reg[gi] <= bus.DIN;
               end
            end
         end
      end
   endgenerate

   assign bus.A           = out_reg[SLOT_A];
   assign bus.B           = out_reg[SLOT_B];
   assign bus.C           = out_reg[SLOT_C];
   assign bus.D           = out_reg[SLOT_D];
   assign bus.FRAME_VALID = frame_valid_reg;
   assign bus.SYNC_ERR    = sync_err_reg;
   assign bus.SEL         = sel_reg;
   assign bus.LOCKED      = (state_reg == LOCKED);

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Self-checking bench for tdm_demultiplexer: directed scenarios plus random
// traffic compared cycle by cycle against a frame-level reference model.
module tb_tdm_demultiplexer;

   localparam int W = 2;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   tdm_demultiplexer_if #(.W(W)) bus ();

   tdm_demultiplexer #(.W(W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model: alignment flag plus the list of beats of the frame in progress
   bit           m_locked;
   logic [W-1:0] m_frame [$];
   logic [W-1:0] m_out [4];
   bit           m_fv;
   bit           m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_locked = 0;
      m_frame.delete();
      for (int i = 0; i < 4; i++) m_out[i] = '0;
      m_fv  = 0;
      m_err = 0;
   endtask

   task automatic model_beat(input bit v, input bit sync, input logic [W-1:0] din);
      m_fv  = 0;
      m_err = 0;
      if (!v) return;
      if (!m_locked) begin
         if (sync) begin
            m_frame.delete();
            m_frame.push_back(din);
            m_locked = 1;
         end
      end else if (m_frame.size() == 0) begin
         if (sync) m_frame.push_back(din);
         else begin
            m_err    = 1;
            m_locked = 0;
         end
      end else if (sync) begin
         m_err = 1;
         m_frame.delete();
         m_frame.push_back(din);
      end else begin
         m_frame.push_back(din);
         if (m_frame.size() == 4) begin
            for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
            m_fv = 1;
            m_frame.delete();
         end
      end
   endtask

   task automatic compare_all(input string ctx);
      check({ctx, ".A"}, 32'(bus.A), 32'(m_out[0]));
      check({ctx, ".B"}, 32'(bus.B), 32'(m_out[1]));
      check({ctx, ".C"}, 32'(bus.C), 32'(m_out[2]));
      check({ctx, ".D"}, 32'(bus.D), 32'(m_out[3]));
      check({ctx, ".FRAME_VALID"}, 32'(bus.FRAME_VALID), 32'(m_fv));
      check({ctx, ".SYNC_ERR"}, 32'(bus.SYNC_ERR), 32'(m_err));
      check({ctx, ".LOCKED"}, 32'(bus.LOCKED), 32'(m_locked));
      check({ctx, ".SEL"}, 32'(bus.SEL), m_locked ? 32'(m_frame.size()) : 32'd0);
   endtask

   // One clock: drive inputs, advance the model, sample just after the edge
   task automatic step(input string ctx, input bit rst, input bit v, input bit sync,
                       input logic [W-1:0] din);
      RST            = rst;
      bus.DIN_VALID  = v;
      bus.FRAME_SYNC = sync;
      bus.DIN        = din;
      if (rst) model_reset();
      else model_beat(v, sync, din);
      @(posedge CLK);
      #1;
      compare_all(ctx);
   endtask

   task automatic beat(input string ctx, input bit sync, input logic [W-1:0] din);
      step(ctx, 1'b0, 1'b1, sync, din);
   endtask

   task automatic idle(input string ctx, input int n);
      for (int i = 0; i < n; i++) step(ctx, 1'b0, 1'b0, 1'b0, 2'(i));
   endtask

   int fv_seen;
   int err_seen;

   initial begin
      bus.DIN = '0;
      bus.DIN_VALID = 1'b0;
      bus.FRAME_SYNC = 1'b0;
      model_reset();

      // Reset then idle
      step("rst", 1'b1, 1'b0, 1'b0, '0);
      step("rst", 1'b1, 1'b1, 1'b1, 2'b11);
      idle("idle", 10);

      // Aligned frame
      beat("aligned", 1, 2'b00);
      beat("aligned", 0, 2'b01);
      beat("aligned", 0, 2'b01);
      beat("aligned", 0, 2'b11);
      check("aligned_commit", {bus.A, bus.B, bus.C, bus.D, bus.FRAME_VALID}, 9'b00_01_01_11_1);
      idle("aligned_post", 2);

      // Gapped frame
      beat("gapped", 1, 2'b00);  idle("gapped", 3);
      beat("gapped", 0, 2'b01);  idle("gapped", 3);
      beat("gapped", 0, 2'b01);  idle("gapped", 3);
      beat("gapped", 0, 2'b11);
      check("gapped_fv", 32'(bus.FRAME_VALID), 32'd1);
      idle("gapped_post", 2);

      // Early sync
      beat("early", 1, 2'b10);
      beat("early", 0, 2'b11);
      beat("early", 1, 2'b01);
      check("early_err", 32'(bus.SYNC_ERR), 32'd1);
      beat("early", 0, 2'b00);
      beat("early", 0, 2'b10);
      beat("early", 0, 2'b11);
      check("early_commit", {bus.A, bus.B, bus.C, bus.D, bus.LOCKED}, 9'b01_00_10_11_1);

      // Missing sync, then ignored beats until a sync
      beat("missing", 0, 2'b10);
      check("missing_err", {bus.SYNC_ERR, bus.LOCKED}, 2'b10);
      beat("missing", 0, 2'b01);
      beat("missing", 0, 2'b11);
      idle("missing", 2);
      beat("missing", 1, 2'b00);
      beat("missing", 0, 2'b10);

      // Reset mid-frame
      step("midrst", 1'b1, 1'b0, 1'b0, '0);
      check("midrst_clear", {bus.A, bus.B, bus.C, bus.D, bus.LOCKED}, 9'd0);
      beat("midrst", 1, 2'b11);
      beat("midrst", 0, 2'b10);
      beat("midrst", 0, 2'b01);
      beat("midrst", 0, 2'b00);
      check("midrst_commit", {bus.A, bus.B, bus.C, bus.D, bus.FRAME_VALID}, 9'b11_10_01_00_1);

      // Back-to-back frames at full rate
      for (int f = 0; f < 3; f++) begin
         for (int s = 0; s < 4; s++) beat("b2b", s == 0, 2'($urandom));
         check("b2b_fv", 32'(bus.FRAME_VALID), 32'd1);
      end

      // Random traffic, mostly well-formed with occasional errors and resets
      fv_seen  = 0;
      err_seen = 0;
      for (int i = 0; i < 3000; i++) begin
         bit rst_r, v_r, sync_r;
         bit at_slot0;
         at_slot0 = !m_locked || (m_frame.size() == 0);
         rst_r  = ($urandom_range(0, 299) == 0);
         v_r    = ($urandom_range(0, 9) < 7);
         sync_r = at_slot0 ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 19) == 0);
         step("rand", rst_r, v_r, sync_r, 2'($urandom));
         if (bus.FRAME_VALID) fv_seen++;
         if (bus.SYNC_ERR) err_seen++;
      end
      check("rand_saw_frames", 32'(fv_seen > 50), 32'd1);
      check("rand_saw_errors", 32'(err_seen > 5), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
